writeback_stage: RTL and testbench

- Final pipeline stage of the RISC-V lite core.
- Registers the MEM-stage result, then selects the writeback source: ALU, load, PC+4 or immediate.
- Aligns and sign/zero-extends load data, then drives the register-file write port (wr_en, add_wr, datain).
- Also provides a forwarding tap for decode and a retired-instruction counter.

---
 rtl/writeback_stage_if.sv | 49 ++++
 rtl/writeback_stage.sv | 128 ++++++++++++
 tb/tb_writeback_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Writeback stage bus: MEM-stage inputs, stage control, register-file write port,
// forwarding tap and retire counter. One cycle from mem_* to the write port.
// Backpressure: wb_stall holds the stage entry; wb_flush squashes it.
interface writeback_stage_if #(
    parameter int NBITS    = 32,
    parameter int CNT_BITS = 32
);
    // MEM-stage side
    logic                mem_valid;
    logic                mem_reg_write;
    logic [4:0]          mem_rd_addr;
    logic [1:0]          mem_wb_sel;
    logic [2:0]          mem_funct3;
    logic [NBITS-1:0]    mem_alu_result;
    logic [NBITS-1:0]    mem_pc_plus4;
    logic [NBITS-1:0]    mem_imm;
    logic [NBITS-1:0]    mem_load_data;
    // stage control
    logic                wb_stall;
    logic                wb_flush;
    // register-file write port and forwarding tap
    logic                wr_en;
    logic [4:0]          add_wr;
    logic [NBITS-1:0]    datain;
    logic                fwd_valid;
    logic [4:0]          fwd_addr;
    logic [NBITS-1:0]    fwd_data;
    // status
    logic                load_fault;
    logic [CNT_BITS-1:0] instret;

    // master: the pipeline around the stage (drives MEM results and control)
    modport master (
        output mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel, mem_funct3,
               mem_alu_result, mem_pc_plus4, mem_imm, mem_load_data,
               wb_stall, wb_flush,
        input  wr_en, add_wr, datain, fwd_valid, fwd_addr, fwd_data,
               load_fault, instret
    );

    // slave: the writeback stage itself
    modport slave (
        input  mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel, mem_funct3,
               mem_alu_result, mem_pc_plus4, mem_imm, mem_load_data,
               wb_stall, wb_flush,
        output wr_en, add_wr, datain, fwd_valid, fwd_addr, fwd_data,
               load_fault, instret
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM result, selects ALU/load/PC+4/imm, extends loads,
// drives the register-file write port, forwarding tap and retired-instruction counter.
// Latency 1 cycle (mem_* -> wr_en/add_wr/datain); wb_stall holds the entry, wb_flush clears it.
// Ports: clk, rst (async, active-high), bus (writeback_stage_if.slave).
module writeback_stage #(
    parameter int NBITS    = 32,
    parameter int CNT_BITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    writeback_stage_if.slave bus
);

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic [4:0]       rd_addr;
        logic [1:0]       wb_sel;
        logic [2:0]       funct3;
        logic [NBITS-1:0] alu_result;
        logic [NBITS-1:0] pc_plus4;
        logic [NBITS-1:0] imm;
        logic [NBITS-1:0] load_data;
    } entry_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    entry_t              stage_q;
    logic [CNT_BITS-1:0] instret_q;

    logic                retire;
    logic                fault;
    logic [1:0]          lane;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [NBITS-1:0]    load_val;
    logic [NBITS-1:0]    wb_val;
    logic                write;

    // Stage register. Flush is applied after the capture so it wins over stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            if (!bus.wb_stall) begin
                stage_q <= '{valid:      bus.mem_valid,
                             reg_write:  bus.mem_reg_write,
                             rd_addr:    bus.mem_rd_addr,
                             wb_sel:     bus.mem_wb_sel,
                             funct3:     bus.mem_funct3,
                             alu_result: bus.mem_alu_result,
                             pc_plus4:   bus.mem_pc_plus4,
                             imm:        bus.mem_imm,
                             load_data:  bus.mem_load_data};
            end
            if (bus.wb_flush) begin
                stage_q.valid <= 1'b0;
            end
        end
    end

    // Load alignment and extension; the byte address low bits pick the lane.
    always_comb begin
        lane     = stage_q.alu_result[1:0];
        ld_byte  = stage_q.load_data[{lane, 3'b000} +: 8];
        ld_half  = lane[1] ? stage_q.load_data[31:16] : stage_q.load_data[15:0];
        load_val = '0;
        fault    = 1'b0;
        case (stage_q.funct3)
            3'b000: load_val = {{(NBITS-8){ld_byte[7]}}, ld_byte};
            3'b100: load_val = {{(NBITS-8){1'b0}}, ld_byte};
            3'b001: begin
                load_val = {{(NBITS-16){ld_half[15]}}, ld_half};
                fault    = lane[0];
            end
            3'b101: begin
                load_val = {{(NBITS-16){1'b0}}, ld_half};
                fault    = lane[0];
            end
            3'b010: begin
                load_val = stage_q.load_data;
                fault    = (lane != 2'b00);
            end
            default: fault = 1'b1;
        endcase
        // Fault only means something for instructions that actually use the load path.
        if (stage_q.wb_sel != SEL_LOAD) begin
            fault = 1'b0;
        end
    end

    always_comb begin
        wb_val = '0;
        if (stage_q.valid) begin
            case (stage_q.wb_sel)
                SEL_ALU:  wb_val = stage_q.alu_result;
                SEL_LOAD: wb_val = load_val;
                SEL_PC4:  wb_val = stage_q.pc_plus4;
                default:  wb_val = stage_q.imm;
            endcase
        end
    end

    // A stalled entry does not retire; it retires once in the first unstalled cycle.
    assign retire = stage_q.valid & ~bus.wb_stall;
    assign write  = retire & stage_q.reg_write & (stage_q.rd_addr != 5'd0) & ~fault;

    // Faulting and non-writing instructions still count as retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign bus.wr_en      = write;
    assign bus.add_wr     = stage_q.valid ? stage_q.rd_addr : 5'd0;
    assign bus.datain     = wb_val;
    assign bus.fwd_valid  = write;
    assign bus.fwd_addr   = bus.add_wr;
    assign bus.fwd_data   = wb_val;
    assign bus.load_fault = retire & fault;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_pc_plus4, mem_imm, mem_load_data;
    logic        wb_stall, wb_flush;

    always #5 clk = ~clk;

    writeback_stage_if #(.NBITS(32), .CNT_BITS(32)) bus_a ();
    writeback_stage_if #(.NBITS(32), .CNT_BITS(4))  bus_b ();

    assign bus_a.mem_valid      = mem_valid;
    assign bus_a.mem_reg_write  = mem_reg_write;
    assign bus_a.mem_rd_addr    = mem_rd_addr;
    assign bus_a.mem_wb_sel     = mem_wb_sel;
    assign bus_a.mem_funct3     = mem_funct3;
    assign bus_a.mem_alu_result = mem_alu_result;
    assign bus_a.mem_pc_plus4   = mem_pc_plus4;
    assign bus_a.mem_imm        = mem_imm;
    assign bus_a.mem_load_data  = mem_load_data;
    assign bus_a.wb_stall       = wb_stall;
    assign bus_a.wb_flush       = wb_flush;

    assign bus_b.mem_valid      = mem_valid;
    assign bus_b.mem_reg_write  = mem_reg_write;
    assign bus_b.mem_rd_addr    = mem_rd_addr;
    assign bus_b.mem_wb_sel     = mem_wb_sel;
    assign bus_b.mem_funct3     = mem_funct3;
    assign bus_b.mem_alu_result = mem_alu_result;
    assign bus_b.mem_pc_plus4   = mem_pc_plus4;
    assign bus_b.mem_imm        = mem_imm;
    assign bus_b.mem_load_data  = mem_load_data;
    assign bus_b.wb_stall       = wb_stall;
    assign bus_b.wb_flush       = wb_flush;

    writeback_stage #(.NBITS(32), .CNT_BITS(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    writeback_stage #(.NBITS(32), .CNT_BITS(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction currently sitting in writeback, plus a retire count.
    bit          m_valid, m_rw;
    bit [4:0]    m_rd;
    bit [1:0]    m_sel;
    bit [2:0]    m_f3;
    bit [31:0]   m_alu, m_pc, m_imm, m_ld;
    longint unsigned m_cnt;

    bit [2:0]  ld_f3  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    bit [1:0]  ld_lo  [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    bit [31:0] ld_exp [6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF,
                              32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    bit [2:0]  ft_f3  [3] = '{3'b010, 3'b001, 3'b011};
    bit [1:0]  ft_lo  [3] = '{2'b10, 2'b01, 2'b00};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fault();
        int lane;
        lane = int'(m_alu % 4);
        if (m_sel != 2'd1) return 1'b0;
        case (m_f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (lane % 2) == 1;
            3'd2:       return lane != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic bit [31:0] model_data();
        int        lane;
        bit [31:0] v;
        lane = int'(m_alu % 4);
        if (!m_valid) return 32'd0;
        if (m_sel == 2'd0) return m_alu;
        if (m_sel == 2'd2) return m_pc;
        if (m_sel == 2'd3) return m_imm;
        v = 32'd0;
        case (m_f3)
            3'd0, 3'd4: begin
                v = (m_ld >> (8 * lane)) & 32'hFF;
                if (m_f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (m_ld >> (16 * (lane / 2))) & 32'hFFFF;
                if (m_f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            default: v = m_ld;
        endcase
        return v;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
        m_alu = 0; m_pc = 0; m_imm = 0; m_ld = 0; m_cnt = 0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit        ret, flt, ex_wr;
        bit [31:0] ex_dat;
        bit [4:0]  ex_addr;
        @(negedge clk);
        ret     = m_valid && !wb_stall && !rst;
        flt     = model_fault();
        ex_wr   = ret && m_rw && (m_rd != 0) && !flt;
        ex_dat  = model_data();
        ex_addr = m_valid ? m_rd : 5'd0;
        check("wr_en", {31'd0, bus_a.wr_en}, {31'd0, ex_wr});
        check("add_wr", {27'd0, bus_a.add_wr}, {27'd0, ex_addr});
        check("fwd_valid", {31'd0, bus_a.fwd_valid}, {31'd0, ex_wr});
        check("fwd_addr", {27'd0, bus_a.fwd_addr}, {27'd0, ex_addr});
        if (!(m_valid && flt)) begin
            check("datain", bus_a.datain, ex_dat);
            check("fwd_data", bus_a.fwd_data, ex_dat);
        end
        check("load_fault", {31'd0, bus_a.load_fault}, {31'd0, ret && flt});
        check("instret", bus_a.instret, m_cnt[31:0]);
        check("instret4", {28'd0, bus_b.instret}, 32'(m_cnt % 16));
        check("wr_en4", {31'd0, bus_b.wr_en}, {31'd0, ex_wr});
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (ret) m_cnt++;
            if (!wb_stall) begin
                m_valid = mem_valid; m_rw = mem_reg_write; m_rd = mem_rd_addr;
                m_sel = mem_wb_sel; m_f3 = mem_funct3; m_alu = mem_alu_result;
                m_pc = mem_pc_plus4; m_imm = mem_imm; m_ld = mem_load_data;
            end
            if (wb_flush) m_valid = 0;
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit rw, input bit [4:0] rd, input bit [1:0] sel,
                         input bit [2:0] f3, input bit [31:0] alu, input bit [31:0] pc,
                         input bit [31:0] imm, input bit [31:0] ld);
        mem_valid = v; mem_reg_write = rw; mem_rd_addr = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_result = alu; mem_pc_plus4 = pc; mem_imm = imm;
        mem_load_data = ld;
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        longint unsigned c0;
        rst = 1'b1; wb_stall = 0; wb_flush = 0;
        model_clear();
        // reset held for three cycles while MEM keeps presenting work
        drive(1, 1, 5'd4, 2'd0, 3'd0, 32'h5555_5555, 32'd0, 32'd0, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        drive(1, 1, 5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'd0, 32'd0, 32'd0);
        #1;
        check("post_rst_wr", {31'd0, bus_a.wr_en}, 32'd0);
        check("post_rst_data", bus_a.datain, 32'd0);
        step();
        check("first_wr", {31'd0, bus_a.wr_en}, 32'd1);
        check("first_addr", {27'd0, bus_a.add_wr}, 32'd5);
        check("first_data", bus_a.datain, 32'h0000_1234);
        idle();
        step();
        check("first_instret", bus_a.instret, 32'd1);

        // load alignment / extension table
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 5'd7, 2'd1, ld_f3[i], {30'h100, ld_lo[i]}, 32'd0, 32'd0, 32'h80FF_7F01);
            step();
            check("ld_data", bus_a.datain, ld_exp[i]);
            check("ld_wr", {31'd0, bus_a.wr_en}, 32'd1);
        end
        idle();
        step();

        // faulting loads: no write, still retire
        for (int i = 0; i < 3; i++) begin
            c0 = m_cnt;
            drive(1, 1, 5'd8, 2'd1, ft_f3[i], {30'h200, ft_lo[i]}, 32'd0, 32'd0, 32'h1357_9BDF);
            step();
            idle();
            check("fault_flag", {31'd0, bus_a.load_fault}, 32'd1);
            check("fault_wr", {31'd0, bus_a.wr_en}, 32'd0);
            step();
            check("fault_instret", bus_a.instret, 32'(c0 + 1));
        end

        // x0 destination
        c0 = m_cnt;
        drive(1, 1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);
        step();
        idle();
        check("x0_wr", {31'd0, bus_a.wr_en}, 32'd0);
        step();
        check("x0_instret", bus_a.instret, 32'(c0 + 1));

        // PC+4 and immediate sources
        drive(1, 1, 5'd3, 2'd2, 3'd0, 32'h0000_0FFF, 32'h0000_0104, 32'h1111_1111, 32'd0);
        step();
        check("pc4_data", bus_a.datain, 32'h0000_0104);
        drive(1, 1, 5'd3, 2'd3, 3'd0, 32'h0000_0FFF, 32'h0000_0104, 32'hABCD_E000, 32'd0);
        step();
        check("imm_data", bus_a.datain, 32'hABCD_E000);

        // two-cycle stall: held, then written once
        drive(1, 1, 5'd9, 2'd0, 3'd0, 32'h0000_CAFE, 32'd0, 32'd0, 32'd0);
        step();
        wb_stall = 1;
        drive(1, 1, 5'd12, 2'd0, 3'd0, 32'h0000_BEEF, 32'd0, 32'd0, 32'd0);
        #1;
        check("stall_wr", {31'd0, bus_a.wr_en}, 32'd0);
        step();
        step();
        wb_stall = 0;
        idle();
        #1;
        check("unstall_wr", {31'd0, bus_a.wr_en}, 32'd1);
        check("unstall_addr", {27'd0, bus_a.add_wr}, 32'd9);
        check("unstall_data", bus_a.datain, 32'h0000_CAFE);
        step();
        check("unstall_once", {31'd0, bus_a.wr_en}, 32'd0);

        // stall and flush together: entry dropped
        drive(1, 1, 5'd10, 2'd0, 3'd0, 32'h0000_0077, 32'd0, 32'd0, 32'd0);
        step();
        idle();
        wb_stall = 1; wb_flush = 1;
        step();
        wb_stall = 0; wb_flush = 0;
        #1;
        check("flush_wr", {31'd0, bus_a.wr_en}, 32'd0);
        check("flush_addr", {27'd0, bus_a.add_wr}, 32'd0);
        step();

        // reset in the middle of a stall
        drive(1, 1, 5'd11, 2'd0, 3'd0, 32'h0000_0011, 32'd0, 32'd0, 32'd0);
        step();
        idle();
        wb_stall = 1;
        step();
        rst = 1;
        model_clear();
        #1;
        check("midrst_wr", {31'd0, bus_a.wr_en}, 32'd0);
        check("midrst_addr", {27'd0, bus_a.add_wr}, 32'd0);
        check("midrst_instret", bus_a.instret, 32'd0);
        wb_stall = 0;
        step();
        rst = 0;

        // 17 retires: 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 5'd1, 2'd0, 3'd0, 32'(i), 32'd0, 32'd0, 32'd0);
            step();
        end
        idle();
        step();
        check("wrap4", {28'd0, bus_b.instret}, 32'd1);
        check("wrap32", bus_a.instret, 32'd17);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 2'($urandom),
                  3'($urandom), $urandom, $urandom, $urandom, $urandom);
            wb_stall = ($urandom_range(0, 3) == 0);
            wb_flush = wb_stall && ($urandom_range(0, 1) == 1);
            step();
        end
        wb_stall = 0; wb_flush = 0;
        idle();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
